pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL provide parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL provide parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL provide parameter INC, default 4, sequential increment in bytes; legal values 2 or 4.
REQ-004 SHALL provide parameter RAS_DEPTH, default 4, return-address-stack entries (used only when PC_GEN_RAS_EN is defined).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port advance  input  1  request sequential increment by INC.
REQ-008 SHALL have port stall  input  1  hold PC this cycle.
REQ-009 SHALL have port redir_en  input  1  branch/jump taken.
REQ-010 SHALL have port redir_target  input  XLEN  branch/jump target.
REQ-011 SHALL have port trap_en  input  1  exception redirect.
REQ-012 SHALL have port trap_vec  input  XLEN  trap handler address.
REQ-013 SHALL have port halt  input  1  single-cycle pulse that requests the HALT state.
REQ-014 SHALL have port call  input  1  the current redirect is a call; push PC+INC.
REQ-015 SHALL have port ret  input  1  return; target comes from the RAS top.
REQ-016 SHALL have port pc_reg  output  XLEN  current PC.
REQ-017 SHALL have port pc_valid  output  1  pc_reg holds a fetchable address.
REQ-018 SHALL have port misalign_err  output  1  one-cycle pulse when a target is rejected.

Function
REQ-019 SHALL implement FSM states BOOT, RUN and HALT.
REQ-020 BOOT SHALL last exactly one cycle after reset deasserts, then go to RUN.
REQ-021 In BOOT, pc_valid SHALL be 0 and pc_reg SHALL be RESET_VEC.
REQ-022 pc_valid SHALL be 1 only in RUN.
REQ-023 In RUN, the next-PC priority SHALL be: trap_en > redir_en > ret > stall > advance > hold.
REQ-024 trap_en SHALL load trap_vec even when stall is asserted.
REQ-025 A trap in HALT SHALL load trap_vec and return to RUN.
REQ-026 redir_en and advance SHALL be ignored while stall=1; the PC holds.
REQ-027 advance SHALL compute pc_reg+INC modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
REQ-028 A redirect or trap target with (target mod INC)!=0 SHALL NOT be loaded; the PC holds and misalign_err pulses on the next cycle.
REQ-029 misalign_err SHALL also pulse for a misaligned trap_vec; the FSM state SHALL be unchanged.
REQ-030 halt SHALL move RUN->HALT on the next edge; the PC freezes and pc_valid=0.
REQ-031 HALT SHALL exit to RUN only on trap_en.
REQ-032 Every PC update SHALL take effect on the edge after the request; latency is 1 cycle, with no combinational input->pc_reg path.

Reset
REQ-033 reset=0 SHALL immediately force pc_reg=RESET_VEC, state=BOOT, pc_valid=0, misalign_err=0 and the RAS count to 0.
REQ-034 Assertion of reset mid-operation SHALL discard any pending redirect, trap or RAS operation.

Configuration
REQ-035 With macro PC_GEN_RAS_EN defined, the block SHALL include a RAS_DEPTH-entry stack.
REQ-036 With PC_GEN_RAS_EN: call&redir_en SHALL push pc_reg+INC.
REQ-037 With PC_GEN_RAS_EN: ret SHALL pop and load the top entry.
REQ-038 With PC_GEN_RAS_EN: a push when full SHALL overwrite the oldest entry (circular).
REQ-039 With PC_GEN_RAS_EN: ret when empty SHALL hold the PC and pulse misalign_err.
REQ-040 Without PC_GEN_RAS_EN, call and ret SHALL be ignored and no stack storage SHALL exist.

Structure
REQ-041 The shared package pc_gen_pkg SHALL hold the FSM state enum (BOOT/RUN/HALT) and the next-PC select encoding constants.
REQ-042 The RAS SHALL be a sub-module named pc_gen_ras, instantiated only under PC_GEN_RAS_EN.

Verification
REQ-043 Reset, release, and advance=1 for 3 cycles -> pc_valid=0 for one cycle, then pc_reg 0x0, 0x4, 0x8, 0xC.
REQ-044 At pc_reg=0x100, redir_en=1, target 0x200, stall=1 -> pc_reg stays 0x100; with stall=0 on the next cycle -> 0x200.
REQ-045 trap_en=1 with trap_vec 0x80, redir_en=1 and stall=1 together -> pc_reg=0x80 next cycle.
REQ-046 redir_target 0x203 with INC=4 -> pc_reg unchanged and misalign_err=1 for exactly 1 cycle.
REQ-047 halt, then advance for 5 cycles -> pc frozen and pc_valid=0; then trap_en, trap_vec 0x40 -> RUN with pc_reg=0x40.
REQ-048 With PC_GEN_RAS_EN: at pc_reg=0x10, call+redir_en to 0x400, then ret -> pc_reg 0x400 then 0x14; a further ret on the empty stack -> PC holds and misalign_err pulses.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// FSM state encoding, next-PC select codes and the target alignment check.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_HOLD  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_ADV   = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_REDIR = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_TRAP  = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_RET   = SEL_W'(4);

  // Only INC of 2 or 4 is legal, so the two low address bits decide alignment.
  function automatic logic is_misaligned(input logic [1:0] lsb, input int unsigned inc);
    logic bad;
    if (inc == 32'd4) begin
      bad = (lsb != 2'b00);
    end else begin
      bad = lsb[0];
    end
    return bad;
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack for pc_gen; a push onto a full stack
// overwrites the oldest entry, a pop on an empty stack is ignored.
module pc_gen_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_c_o,
  output logic            empty_c_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] top_idx_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ptr_q is the next write slot; the top of stack sits one slot below it.
  assign top_idx_c = (ptr_q == PTR_W'(0)) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
  assign top_c_o   = mem_q[top_idx_c];
  assign empty_c_o = (cnt_q == CNT_W'(0));

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_c_o) begin
      ptr_d = top_idx_c;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_W'(0);
      cnt_q <= CNT_W'(0);
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT/RUN/HALT control and registered outputs.
// Optional return-address stack is built when PC_GEN_RAS_EN is defined.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  input  logic            stall,
  input  logic            redir_en,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc_reg,
  output logic            pc_valid,
  output logic            misalign_err
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_inc_c;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  sel_c;
  logic              trap_bad_c, redir_bad_c;
  logic              call_c, ret_c;
  logic              ras_push_c, ras_pop_c, ras_empty_c;
  logic [XLEN-1:0]   ras_top_c;

  assign pc_inc_c    = pc_q + XLEN'(INC);
  assign trap_bad_c  = is_misaligned(trap_vec[1:0], INC);
  assign redir_bad_c = is_misaligned(redir_target[1:0], INC);

`ifdef PC_GEN_RAS_EN
  assign call_c = call;
  assign ret_c  = ret;

  pc_gen_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (ras_push_c),
    .pop_i       (ras_pop_c),
    .push_data_i (pc_inc_c),
    .top_c_o     (ras_top_c),
    .empty_c_o   (ras_empty_c)
  );
`else
  localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;

  logic unused_ras_c;

  assign call_c       = 1'b0;
  assign ret_c        = 1'b0;
  assign ras_top_c    = '0;
  assign ras_empty_c  = 1'b1;
  assign unused_ras_c = call ^ ret ^ ras_push_c ^ ras_pop_c;
`endif

  // Control: trap beats everything (even stall); stall only blocks redirect and advance.
  always_comb begin
    state_d    = state_q;
    sel_c      = SEL_HOLD;
    err_d      = 1'b0;
    ras_push_c = 1'b0;
    ras_pop_c  = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (trap_en) begin
          if (trap_bad_c) begin
            err_d = 1'b1;
          end else begin
            sel_c = SEL_TRAP;
          end
        end else if (halt) begin
          state_d = HALT;
        end else if (redir_en && !stall) begin
          if (redir_bad_c) begin
            err_d = 1'b1;
          end else begin
            sel_c      = SEL_REDIR;
            ras_push_c = call_c;
          end
        end else if (ret_c) begin
          if (ras_empty_c) begin
            err_d = 1'b1;
          end else begin
            sel_c     = SEL_RET;
            ras_pop_c = 1'b1;
          end
        end else if (advance && !stall) begin
          sel_c = SEL_ADV;
        end
      end
      HALT: begin
        if (trap_en) begin
          if (trap_bad_c) begin
            err_d = 1'b1;
          end else begin
            sel_c   = SEL_TRAP;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Next-PC mux.
  always_comb begin
    pc_d = pc_q;
    case (sel_c)
      SEL_ADV:   pc_d = pc_inc_c;
      SEL_REDIR: pc_d = redir_target;
      SEL_TRAP:  pc_d = trap_vec;
      SEL_RET:   pc_d = ras_top_c;
      default:   pc_d = pc_q;
    endcase
  end

  assign valid_d = (state_d == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign pc_reg       = pc_q;
  assign pc_valid     = valid_q;
  assign misalign_err = err_q;

endmodule
